// File: rtl/crack_multi_ctrl.sv
// crack_multi_ctrl: launches NUM_CORES ARC4 crack cores, keeps the lowest-index valid key.
// Define CRACK_TIMEOUT_EN to add a RUN-phase watchdog that forces FAIL after TIMEOUT_CYCLES.
module crack_multi_ctrl #(
    parameter int unsigned NUM_CORES      = 4,
    parameter int unsigned KEY_W          = 24,
    parameter int unsigned DIGITS         = KEY_W / 4,
    parameter int unsigned TIMEOUT_CYCLES = 2**26
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            start,
    output logic                                            busy,
    output logic                                            done,
    output logic                                            key_valid,
    output logic [KEY_W-1:0]                                key,
    output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] winner,
    output logic                                            timed_out,
    output logic [NUM_CORES-1:0]                            core_rst_n,
    output logic [NUM_CORES-1:0]                            core_en,
    input  logic [NUM_CORES-1:0]                            core_rdy,
    input  logic [NUM_CORES-1:0]                            core_key_valid,
    input  logic [NUM_CORES*KEY_W-1:0]                      core_key,
    output logic [7*DIGITS-1:0]                             hex_seg
);

    localparam int unsigned WIN_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitRdy,
        StLaunch,
        StSettle,
        StRun,
        StAbort,
        StDone,
        StFail
    } state_e;

    state_e               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 key_valid_q, key_valid_d;
    logic [KEY_W-1:0]     key_q, key_d;
    logic [KEY_W-1:0]     win_key_q, win_key_d;
    logic [WIN_W-1:0]     winner_q, winner_d;
    logic                 timed_out_q, timed_out_d;
    logic [NUM_CORES-1:0] core_en_q, core_en_d;
    logic [NUM_CORES-1:0] core_rst_q, core_rst_d;
    logic [NUM_CORES-1:0] finished_q, finished_d;

    logic [NUM_CORES-1:0] fin_now;
    logic [NUM_CORES-1:0] cand;
    logic [WIN_W-1:0]     cand_idx;
    logic                 timeout_hit;

    assign fin_now = finished_q | core_rdy;
    assign cand    = fin_now & core_key_valid;

    // Descending scan so the lowest set index is the last one assigned.
    always_comb begin
        cand_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (cand[i]) begin
                cand_idx = WIN_W'(i);
            end
        end
    end

`ifdef CRACK_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_hit = (cnt_q >= CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StLaunch) begin
            cnt_d = '0;
        end else if ((state_q == StSettle || state_q == StRun) && !timeout_hit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = done_q;
        key_valid_d = key_valid_q;
        key_d       = key_q;
        win_key_d   = win_key_q;
        winner_d    = winner_q;
        timed_out_d = timed_out_q;
        core_en_d   = '0;
        core_rst_d  = '1;
        finished_d  = finished_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWaitRdy;
                    busy_d  = 1'b1;
                end
            end
            StWaitRdy: begin
                if (&core_rdy) begin
                    state_d   = StLaunch;
                    core_en_d = '1;
                end
            end
            StLaunch: begin
                finished_d = '0;
                state_d    = StSettle;
            end
            // Cores may still show the stale ready from before launch here.
            StSettle: begin
                state_d = StRun;
            end
            StRun: begin
                finished_d = fin_now;
                if (|cand) begin
                    state_d              = StAbort;
                    winner_d             = cand_idx;
                    win_key_d            = core_key[cand_idx*KEY_W +: KEY_W];
                    core_rst_d           = '0;
                    core_rst_d[cand_idx] = 1'b1;
                end else if (&fin_now) begin
                    state_d = StFail;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    key_d   = '0;
                end else if (timeout_hit) begin
                    state_d     = StFail;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    key_d       = '0;
                    timed_out_d = 1'b1;
                    core_rst_d  = '0;
                end
            end
            StAbort: begin
                state_d     = StDone;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                key_valid_d = 1'b1;
                key_d       = win_key_q;
            end
            StDone, StFail: begin
                if (start) begin
                    state_d     = StWaitRdy;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    key_valid_d = 1'b0;
                    key_d       = '0;
                    winner_d    = '0;
                    timed_out_d = 1'b0;
                end
            end
            default: begin
                state_d     = StIdle;
                busy_d      = 1'b0;
                done_d      = 1'b0;
                key_valid_d = 1'b0;
                key_d       = '0;
                winner_d    = '0;
                timed_out_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_valid_q <= 1'b0;
            key_q       <= '0;
            win_key_q   <= '0;
            winner_q    <= '0;
            timed_out_q <= 1'b0;
            core_en_q   <= '0;
            core_rst_q  <= '0;
            finished_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            key_valid_q <= key_valid_d;
            key_q       <= key_d;
            win_key_q   <= win_key_d;
            winner_q    <= winner_d;
            timed_out_q <= timed_out_d;
            core_en_q   <= core_en_d;
            core_rst_q  <= core_rst_d;
            finished_q  <= finished_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign key_valid  = key_valid_q;
    assign key        = key_q;
    assign winner     = winner_q;
    assign timed_out  = timed_out_q;
    assign core_en    = core_en_q;
    assign core_rst_n = core_rst_q;

    // Active-low segments, bit 6 = g ... bit 0 = a.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        hex_seg = '1;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (state_q == StDone) begin
                hex_seg[7*d +: 7] = hex7(key_q[4*d +: 4]);
            end else if (state_q == StFail) begin
                hex_seg[7*d +: 7] = 7'b0111111;
            end
        end
    end

endmodule

// File: tb/tb_crack_multi_ctrl.sv
// Directed bench for crack_multi_ctrl with four cores and 24-bit keys.
// Define CRACK_TIMEOUT_EN for both files to also exercise the watchdog.
module tb_crack_multi_ctrl;

    localparam int unsigned NC = 4;
    localparam int unsigned KW = 24;
    localparam int unsigned DG = KW / 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           busy;
    logic           done;
    logic           key_valid;
    logic [KW-1:0]  key;
    logic [1:0]     winner;
    logic           timed_out;
    logic [NC-1:0]  core_rst_n;
    logic [NC-1:0]  core_en;
    logic [NC-1:0]  core_rdy;
    logic [NC-1:0]  core_key_valid;
    logic [NC*KW-1:0] core_key;
    logic [7*DG-1:0] hex_seg;

    int checks = 0;
    int errors = 0;

    localparam logic [41:0] HexBlank = {42{1'b1}};
    localparam logic [41:0] HexDash  = {6{7'h3F}};
    // "00EF42": digits 5..0 = 0,0,E,F,4,2
    localparam logic [41:0] HexKey   = {7'h40, 7'h40, 7'h06, 7'h0E, 7'h19, 7'h24};

    crack_multi_ctrl #(
        .NUM_CORES     (NC),
        .KEY_W         (KW),
        .DIGITS        (DG),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .key_valid     (key_valid),
        .key           (key),
        .winner        (winner),
        .timed_out     (timed_out),
        .core_rst_n    (core_rst_n),
        .core_en       (core_en),
        .core_rdy      (core_rdy),
        .core_key_valid(core_key_valid),
        .core_key      (core_key),
        .hex_seg       (hex_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int en_pulses;
    logic [NC-1:0] en_seen;

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        core_rdy       = '0;
        core_key_valid = '0;
        core_key       = '0;
        tick();
        tick();

        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_kv", 64'(key_valid), 64'd0);
        check("rst_key", 64'(key), 64'd0);
        check("rst_winner", 64'(winner), 64'd0);
        check("rst_to", 64'(timed_out), 64'd0);
        check("rst_en", 64'(core_en), 64'd0);
        check("rst_crst", 64'(core_rst_n), 64'd0);
        check("rst_hex", 64'(hex_seg), 64'(HexBlank));

        rst_n = 1'b1;
        #1;
        check("rel_crst_hold", 64'(core_rst_n), 64'd0);
        tick();
        check("rel_crst_up", 64'(core_rst_n), 64'hF);

        // Run 1: one core not ready holds off the launch.
        core_rdy = 4'b0111;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r1_busy", 64'(busy), 64'd1);
        en_pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (core_en != '0) en_pulses++;
        end
        check("r1_wait_no_en", 64'(en_pulses), 64'd0);
        core_rdy = 4'b1111;
        tick();
        check("r1_launch_en", 64'(core_en), 64'hF);
        tick();
        check("r1_settle_en", 64'(core_en), 64'd0);
        tick();
        core_rdy = 4'b0000;
        tick();
        check("r1_settle_ignored", 64'(done), 64'd0);
        check("r1_run_busy", 64'(busy), 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r1_start_ign_busy", 64'(busy), 64'd1);
        check("r1_start_ign_en", 64'(core_en), 64'd0);
        check("r1_run_hex", 64'(hex_seg), 64'(HexBlank));

        core_rdy       = 4'b1010;
        core_key_valid = 4'b1010;
        core_key[3*KW +: KW] = 24'hABCDEF;
        core_key[1*KW +: KW] = 24'h00EF42;
        tick();
        check("r1_abort_winner", 64'(winner), 64'd1);
        check("r1_abort_crst", 64'(core_rst_n), 64'b0010);
        check("r1_abort_key0", 64'(key), 64'd0);
        check("r1_abort_done", 64'(done), 64'd0);
        core_rdy       = 4'b1111;
        core_key_valid = 4'b0000;
        tick();
        check("r1_done_key", 64'(key), 64'h00EF42);
        check("r1_done_kv", 64'(key_valid), 64'd1);
        check("r1_done_done", 64'(done), 64'd1);
        check("r1_done_busy", 64'(busy), 64'd0);
        check("r1_done_crst", 64'(core_rst_n), 64'hF);
        check("r1_done_hex", 64'(hex_seg), 64'(HexKey));
        tick();
        tick();
        check("r1_hold_key", 64'(key), 64'h00EF42);
        check("r1_hold_winner", 64'(winner), 64'd1);

        // Run 2: restart from DONE, all cores finish invalid at staggered times.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r2_clr_key", 64'(key), 64'd0);
        check("r2_clr_kv", 64'(key_valid), 64'd0);
        check("r2_clr_winner", 64'(winner), 64'd0);
        check("r2_clr_done", 64'(done), 64'd0);
        check("r2_busy", 64'(busy), 64'd1);
        en_pulses = 0;
        en_seen   = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (core_en != '0) begin
                en_pulses++;
                en_seen = core_en;
            end
            if (i == 1) core_rdy = 4'b0000;
        end
        check("r2_en_count", 64'(en_pulses), 64'd1);
        check("r2_en_value", 64'(en_seen), 64'hF);
        core_rdy = 4'b0001;
        tick();
        core_rdy = 4'b0100;
        tick();
        core_rdy = 4'b0010;
        tick();
        check("r2_partial_done", 64'(done), 64'd0);
        core_rdy = 4'b1000;
        tick();
        check("r2_fail_done", 64'(done), 64'd1);
        check("r2_fail_busy", 64'(busy), 64'd0);
        check("r2_fail_kv", 64'(key_valid), 64'd0);
        check("r2_fail_key", 64'(key), 64'd0);
        check("r2_fail_to", 64'(timed_out), 64'd0);
        check("r2_fail_hex", 64'(hex_seg), 64'(HexDash));
        check("r2_fail_crst", 64'(core_rst_n), 64'hF);

        // Run 3: asynchronous reset in the middle of RUN.
        core_rdy = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        core_rdy = 4'b0000;
        tick();
        tick();
        check("r3_run_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("r3_rst_crst", 64'(core_rst_n), 64'd0);
        check("r3_rst_busy", 64'(busy), 64'd0);
        check("r3_rst_hex", 64'(hex_seg), 64'(HexBlank));
        tick();
        rst_n = 1'b1;
        #1;
        check("r3_rel_crst0", 64'(core_rst_n), 64'd0);
        tick();
        check("r3_rel_crst1", 64'(core_rst_n), 64'hF);
        check("r3_idle_done", 64'(done), 64'd0);

`ifdef CRACK_TIMEOUT_EN
        // Run 4: cores never finish, watchdog at RUN cycle 100.
        core_rdy = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        core_rdy = 4'b0000;
        tick();
        for (int i = 0; i < 99; i++) tick();
        check("r4_pre_done", 64'(done), 64'd0);
        tick();
        check("r4_to_done", 64'(done), 64'd1);
        check("r4_to_flag", 64'(timed_out), 64'd1);
        check("r4_to_crst", 64'(core_rst_n), 64'd0);
        check("r4_to_hex", 64'(hex_seg), 64'(HexDash));
        tick();
        check("r4_crst_back", 64'(core_rst_n), 64'hF);
        check("r4_hold_to", 64'(timed_out), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
